// File: rtl/weight_pkg.sv
// weight_pkg: shared defaults and state enums for the weight feeder.
package weight_pkg;
    localparam int DATA_W_D = 8;
    localparam int COLS_D = 8;
    localparam int ROWS_D = 7;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, STREAMING} bank_state_t;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, STREAM} feed_state_t;
endpackage

// File: rtl/weight_feeder_if.sv
// weight_feeder_if: host row-write and controller load/weight-row signals.
interface weight_feeder_if #(
    parameter int DATA_W = weight_pkg::DATA_W_D,
    parameter int COLS = weight_pkg::COLS_D
);
    logic w_valid;
    logic [COLS*DATA_W-1:0] w_data;
    logic w_ready;
    logic trigger_weight;
    logic load;
    logic [COLS*DATA_W-1:0] weight_row;
    logic weight_valid;
    modport master (
        output w_valid, w_data, load,
        input w_ready, trigger_weight, weight_row, weight_valid
    );
    modport slave (
        input w_valid, w_data, load,
        output w_ready, trigger_weight, weight_row, weight_valid
    );
endinterface

// File: rtl/weight_bank.sv
// weight_bank: ROWS-deep row register file, one write port, async read port.
module weight_bank #(
    parameter int DATA_W = 8,
    parameter int COLS = 8,
    parameter int ROWS = 7,
    parameter int PW = 3
) (
    input  logic clk,
    input  logic we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [COLS*DATA_W-1:0] wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [COLS*DATA_W-1:0] rdata_o
);
    logic [COLS*DATA_W-1:0] mem_q [ROWS];
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/weight_feeder.sv
// weight_feeder: ping-pong weight matrix buffer feeding the systolic array.
// Host fills banks row by row; a full bank is streamed one row per load cycle.
module weight_feeder
    import weight_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int COLS = COLS_D,
    parameter int ROWS = ROWS_D
) (
    input  logic clk,
    input  logic rst,
    weight_feeder_if.slave wf,
    output logic underrun_err_o,
    output logic short_err_o
);
    localparam int W = COLS * DATA_W;
    localparam int PW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(ROWS + 1);
    bank_state_t bst_q [2];
    bank_state_t bst_d [2];
    feed_state_t st_q, st_d;
    logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic underrun_q, underrun_d, short_q, short_d;
    logic any_full, both_full, oldest, rd_sel, ready, wr_fire, wr_last, rd_done, valid;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0] rdata [2];
    assign any_full = bst_q[0] == FULL || bst_q[1] == FULL;
    assign both_full = bst_q[0] == FULL && bst_q[1] == FULL;
    // Banks fill alternately, so with both full the write pointer sits on the older one.
    assign oldest = both_full ? wr_bank_q : bst_q[1] == FULL;
    assign rd_sel = st_q == WAIT ? oldest : rd_bank_q;
    assign rd_done = rd_cnt_q == CW'(ROWS);
    assign rd_ptr = rd_done ? PW'(ROWS - 1) : PW'(rd_cnt_q);
    assign ready = bst_q[wr_bank_q] == EMPTY || bst_q[wr_bank_q] == FILLING;
    assign wr_fire = wf.w_valid && ready;
    assign wr_last = wr_ptr_q == PW'(ROWS - 1);
    assign valid = wf.load && (st_q == WAIT || st_q == STREAM);
    assign wf.w_ready = ready;
    assign wf.trigger_weight = st_q == REQ;
    assign wf.weight_valid = valid;
    assign wf.weight_row = valid ? rdata[rd_sel] : '0;
    assign underrun_err_o = underrun_q;
    assign short_err_o = short_q;
    for (genvar g = 0; g < 2; g++) begin : g_bank
        weight_bank #(.DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .PW(PW)) u_bank (
            .clk(clk),
            .we_i(wr_fire && wr_bank_q == 1'(g)),
            .waddr_i(wr_ptr_q),
            .wdata_i(wf.w_data),
            .raddr_i(rd_ptr),
            .rdata_o(rdata[g])
        );
    end
    always_comb begin
        bst_d = bst_q;
        st_d = st_q;
        wr_bank_d = wr_bank_q;
        wr_ptr_d = wr_ptr_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d = rd_cnt_q;
        underrun_d = underrun_q;
        short_d = short_q;
        if (wr_fire) begin
            wr_ptr_d = wr_last ? '0 : wr_ptr_q + 1'b1;
            bst_d[wr_bank_q] = wr_last ? FULL : FILLING;
            wr_bank_d = wr_bank_q ^ wr_last;
        end
        case (st_q)
            IDLE: begin
                st_d = any_full ? REQ : IDLE;
                underrun_d = underrun_q | (wf.load && !any_full);
            end
            REQ: begin
                st_d = WAIT;
                underrun_d = underrun_q | (wf.load && !any_full);
            end
            WAIT: if (wf.load) begin
                st_d = STREAM;
                rd_bank_d = oldest;
                bst_d[oldest] = STREAMING;
                rd_cnt_d = CW'(1);
            end
            STREAM: if (wf.load) begin
                rd_cnt_d = rd_done ? rd_cnt_q : rd_cnt_q + 1'b1;
                short_d = short_q | rd_done;
            end else begin
                st_d = IDLE;
                bst_d[rd_bank_q] = EMPTY;
                rd_cnt_d = '0;
                short_d = short_q | !rd_done;
            end
            default: st_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bst_q <= '{EMPTY, EMPTY};
            st_q <= IDLE;
            wr_bank_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_bank_q <= 1'b0;
            rd_cnt_q <= '0;
            underrun_q <= 1'b0;
            short_q <= 1'b0;
        end else begin
            bst_q <= bst_d;
            st_q <= st_d;
            wr_bank_q <= wr_bank_d;
            wr_ptr_q <= wr_ptr_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q <= rd_cnt_d;
            underrun_q <= underrun_d;
            short_q <= short_d;
        end
    end
endmodule

// File: tb/tb_weight_feeder.sv
// tb_weight_feeder: directed sequence with random matrices against a FIFO-of-matrices model.
module tb_weight_feeder;
    import weight_pkg::*;
    localparam int W = COLS_D * DATA_W_D;
    localparam int R = ROWS_D;
    typedef logic [R*W-1:0] mat_t;
    logic clk = 1'b0;
    logic rst;
    logic underrun, short_err;
    int vectors = 0;
    int miscompares = 0;
    mat_t full_q[$];
    mat_t m0, m1, m2;
    bit under_exp, short_exp;
    weight_feeder_if #(.DATA_W(DATA_W_D), .COLS(COLS_D)) wf ();
    weight_feeder #(.DATA_W(DATA_W_D), .COLS(COLS_D), .ROWS(ROWS_D)) dut (
        .clk(clk),
        .rst(rst),
        .wf(wf),
        .underrun_err_o(underrun),
        .short_err_o(short_err)
    );
    always #5 clk = ~clk;
    function automatic logic [W-1:0] row_of(mat_t m, int r);
        return m[r*W +: W];
    endfunction
    function automatic mat_t rand_mat();
        mat_t m;
        for (int r = 0; r < R; r++) m[r*W +: W] = W'({$urandom, $urandom});
        return m;
    endfunction
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_flags();
        chk("underrun_err", underrun, under_exp);
        chk("short_err", short_err, short_exp);
    endtask
    task automatic chk_reset_outputs();
        chk("rst_w_ready", wf.w_ready, 1);
        chk("rst_trigger", wf.trigger_weight, 0);
        chk("rst_weight_valid", wf.weight_valid, 0);
        chk("rst_weight_row", wf.weight_row, 0);
        chk_flags();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        full_q.delete();
        under_exp = 0;
        short_exp = 0;
    endtask
    task automatic wait_trig(input int pre);
        for (int i = 0; i < pre; i++) begin
            chk("trigger_early", wf.trigger_weight, 0);
            tick();
        end
        chk("trigger_pulse", wf.trigger_weight, 1);
        tick();
        chk("trigger_single", wf.trigger_weight, 0);
    endtask
    // Applies nload load cycles and nwr row writes starting together; a stream pops the oldest full matrix.
    task automatic xfer(input int nload, input int nwr, input mat_t wm, input bit streams, input bit exp_ready);
        mat_t rm;
        bit exp_v;
        int n;
        rm = '0;
        if (streams && full_q.size() > 0) rm = full_q.pop_front();
        n = nload > nwr ? nload : nwr;
        for (int i = 0; i < n; i++) begin
            wf.load = i < nload;
            wf.w_valid = i < nwr;
            wf.w_data = i < nwr ? row_of(wm, i) : '0;
            #1;
            exp_v = streams && i < nload;
            chk("weight_valid", wf.weight_valid, exp_v);
            chk("weight_row", wf.weight_row, exp_v ? row_of(rm, i < R ? i : R - 1) : '0);
            if (i < nwr) chk("w_ready", wf.w_ready, exp_ready);
            if (i < nload && !streams) under_exp = 1;
            tick();
        end
        wf.load = 1'b0;
        wf.w_valid = 1'b0;
        wf.w_data = '0;
        if (streams && nload != R) short_exp = 1;
        if (nwr == R) full_q.push_back(wm);
    endtask
    initial begin
        wf.load = 1'b0;
        wf.w_valid = 1'b0;
        wf.w_data = '0;
        rst = 1'b1;
        tick();
        do_reset();
        chk_reset_outputs();
        m0 = rand_mat();
        for (int r = 0; r < R; r++) m0[r*W +: 8] = 8'(r + 1);
        xfer(0, R, m0, 0, 1);
        wait_trig(1);
        xfer(R, 0, '0, 1, 1);
        tick();
        chk_flags();
        m1 = rand_mat();
        m2 = rand_mat();
        xfer(0, R, m1, 0, 1);
        xfer(0, R, m2, 0, 1);
        chk("both_full_w_ready", wf.w_ready, 0);
        xfer(R, 0, '0, 1, 0);
        chk("streaming_w_ready", wf.w_ready, 0);
        tick();
        chk("freed_w_ready", wf.w_ready, 1);
        wait_trig(1);
        xfer(R, 0, '0, 1, 1);
        tick();
        m1 = rand_mat();
        m2 = rand_mat();
        xfer(0, R, m1, 0, 1);
        wait_trig(1);
        xfer(R, R, m2, 1, 1);
        wait_trig(2);
        xfer(R, 0, '0, 1, 1);
        tick();
        chk_flags();
        xfer(1, 0, '0, 0, 1);
        chk_flags();
        repeat (3) tick();
        chk_flags();
        m1 = rand_mat();
        xfer(0, R, m1, 0, 1);
        wait_trig(1);
        xfer(4, 0, '0, 1, 1);
        tick();
        chk_flags();
        chk("short_w_ready", wf.w_ready, 1);
        do_reset();
        chk_flags();
        m1 = rand_mat();
        xfer(0, R, m1, 0, 1);
        wait_trig(1);
        xfer(R + 2, 0, '0, 1, 1);
        tick();
        chk_flags();
        do_reset();
        m1 = rand_mat();
        xfer(0, R, m1, 0, 1);
        wait_trig(1);
        xfer(3, 0, '0, 1, 1);
        wf.load = 1'b1;
        do_reset();
        wf.load = 1'b0;
        chk_reset_outputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_trigger", wf.trigger_weight, 0);
        end
        m2 = rand_mat();
        xfer(0, R, m2, 0, 1);
        wait_trig(1);
        xfer(R, 0, '0, 1, 1);
        tick();
        chk_flags();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
